// File: rtl/seq_signed_divider_if.sv
// Start/result bundle between a requester and seq_signed_divider.
interface seq_signed_divider_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
   logic             overflow;

   modport master (
      output start, signed_mode, dividend, divisor,
      input  ready, busy, done, quotient, remainder, div_by_zero, overflow
   );

   modport slave (
      input  start, signed_mode, dividend, divisor,
      output ready, busy, done, quotient, remainder, div_by_zero, overflow
   );
endinterface

// File: rtl/seq_signed_divider.sv
// Multi-cycle restoring divider (signed/unsigned), quotient truncated toward zero.
// Optional DIV_EARLY_TERM_EN skips the leading-zero iterations of |dividend|.
module seq_signed_divider #(
   parameter int WIDTH = 16
) (
   input  logic                clk,
   input  logic                reset,
   seq_signed_divider_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ALL1    = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_ITER = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t           state_q;
   logic             signed_q;
   logic             qneg_q;
   logic             rneg_q;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] dvs_mag_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] sh_q;
   logic [CW-1:0]    cnt_q;
   logic             ready_q;
   logic             busy_q;
   logic             done_q;
   logic             dbz_q;
   logic             ovf_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;

   logic             dvd_neg_s;
   logic             dvs_neg_s;
   logic             ovf_s;
   logic [WIDTH-1:0] dvd_mag_s;
   logic [WIDTH-1:0] dvs_mag_s;
   logic [WIDTH-1:0] q_fix_s;
   logic [WIDTH-1:0] r_fix_s;
   logic [WIDTH:0]   shifted_s;
   logic [WIDTH:0]   trial_s;

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
      negate = ~v + ONE;
   endfunction

`ifdef DIV_EARLY_TERM_EN
   logic [CW-1:0] lz_s;

   function automatic logic [CW-1:0] lead_zeros(input logic [WIDTH-1:0] v);
      lead_zeros = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         lead_zeros = v[i] ? CW'(WIDTH - 1 - i) : lead_zeros;
      end
   endfunction

   assign lz_s = lead_zeros(dvd_mag_s);
`endif

   // Operand magnitudes, one restoring step, and final sign correction.
   always_comb begin
      dvd_neg_s = signed_q & dvd_q[WIDTH-1];
      dvs_neg_s = signed_q & dvs_q[WIDTH-1];
      dvd_mag_s = dvd_neg_s ? negate(dvd_q) : dvd_q;
      dvs_mag_s = dvs_neg_s ? negate(dvs_q) : dvs_q;
      // rem < |divisor| keeps the difference inside WIDTH+1 signed bits
      shifted_s = {rem_q, sh_q[WIDTH-1]};
      trial_s   = shifted_s - {1'b0, dvs_mag_q};
      q_fix_s   = qneg_q ? negate(sh_q) : sh_q;
      r_fix_s   = rneg_q ? negate(rem_q) : rem_q;
      ovf_s     = signed_q & (dvd_q == MIN_NEG) & (dvs_q == ALL1);
   end

   // Control FSM with datapath registers and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         signed_q    <= 1'b0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         dvd_q       <= ZERO;
         dvs_q       <= ZERO;
         dvs_mag_q   <= ZERO;
         rem_q       <= ZERO;
         sh_q        <= ZERO;
         cnt_q       <= {CW{1'b0}};
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
         quotient_q  <= ZERO;
         remainder_q <= ZERO;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  signed_q <= bus.signed_mode;
                  dvd_q    <= bus.dividend;
                  dvs_q    <= bus.divisor;
                  dbz_q    <= 1'b0;
                  ovf_q    <= 1'b0;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= S_PREP;
               end else begin
                  ready_q  <= 1'b1;
                  state_q  <= S_IDLE;
               end
            end
            S_PREP: begin
               if (dvs_q == ZERO) begin
                  quotient_q  <= ALL1;
                  remainder_q <= dvd_q;
                  dbz_q       <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_DONE;
               end else begin
                  dvs_mag_q <= dvs_mag_s;
                  qneg_q    <= dvd_neg_s ^ dvs_neg_s;
                  rneg_q    <= dvd_neg_s;
                  rem_q     <= ZERO;
`ifdef DIV_EARLY_TERM_EN
                  sh_q      <= dvd_mag_s << lz_s;
                  cnt_q     <= CW'(WIDTH) - lz_s;
                  state_q   <= (dvd_mag_s == ZERO) ? S_FIX : S_ITER;
`else
                  sh_q      <= dvd_mag_s;
                  cnt_q     <= CW'(WIDTH);
                  state_q   <= S_ITER;
`endif
               end
            end
            S_ITER: begin
               rem_q <= trial_s[WIDTH] ? shifted_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
               sh_q  <= {sh_q[WIDTH-2:0], ~trial_s[WIDTH]};
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q <= S_FIX;
               end else begin
                  state_q <= S_ITER;
               end
            end
            S_FIX: begin
               quotient_q  <= q_fix_s;
               remainder_q <= r_fix_s;
               ovf_q       <= ovf_s;
               busy_q      <= 1'b0;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b1;
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ready       = ready_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider: directed vectors, queued expectations, done-driven monitor.
module tb_seq_signed_divider;
   localparam int W = 16;

   typedef struct {
      string        name;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      logic         ovf;
      int           lat;
      int           t0;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   exp_t sb_q[$];
   exp_t mon_e;
   int   t0_main;

   seq_signed_divider_if #(.WIDTH(W)) bus ();
   seq_signed_divider #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic int exp_lat(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_EARLY_TERM_EN
      logic [W-1:0] m;
      int lz;
      if (b == 16'd0) return 2;
      m  = (sm && a[W-1]) ? (~a + 16'd1) : a;
      lz = W;
      for (int i = 0; i < W; i++) if (m[i]) lz = W - 1 - i;
      return W - lz + 3;
`else
      if (b == 16'd0) return 2;
      if (sm === 1'bx || a === 16'hxxxx) return 0;
      return W + 3;
`endif
   endfunction

   // Monitor: every done pulse pops one expectation and compares results and latency.
   always @(negedge clk) begin
      if (!reset && bus.done === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("spurious_done", 16'(bus.done), 16'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check({mon_e.name, "/quotient"},  bus.quotient,          mon_e.q);
            check({mon_e.name, "/remainder"}, bus.remainder,         mon_e.r);
            check({mon_e.name, "/dbz"},       16'(bus.div_by_zero),  16'(mon_e.dbz));
            check({mon_e.name, "/ovf"},       16'(bus.overflow),     16'(mon_e.ovf));
            check({mon_e.name, "/latency"},   16'(cyc - mon_e.t0),   16'(mon_e.lat));
         end
      end
   end

   task automatic launch(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b, output int t0);
      bus.start       = 1'b1;
      bus.signed_mode = sm;
      bus.dividend    = a;
      bus.divisor     = b;
      @(negedge clk);
      t0        = cyc;
      bus.start = 1'b0;
   endtask

   task automatic push_exp(input string nm, input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                           input logic eovf, input int t0);
      exp_t e;
      e.name = nm;
      e.q    = eq;
      e.r    = er;
      e.dbz  = edbz;
      e.ovf  = eovf;
      e.lat  = exp_lat(sm, a, b);
      e.t0   = t0;
      sb_q.push_back(e);
   endtask

   task automatic drain(input string nm);
      for (int k = 0; k < 64 && sb_q.size() != 0; k++) @(negedge clk);
      if (sb_q.size() != 0) begin
         check({nm, "/timeout"}, 16'(sb_q.size()), 16'd0);
         sb_q.delete();
      end
   endtask

   task automatic run_op(input string nm, input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz, input logic eovf);
      int t0;
      check({nm, "/ready"}, 16'(bus.ready), 16'd1);
      launch(sm, a, b, t0);
      push_exp(nm, sm, a, b, eq, er, edbz, eovf, t0);
      check({nm, "/busy"}, 16'(bus.busy), 16'd1);
      drain(nm);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      bus.start       = 1'b0;
      bus.signed_mode = 1'b0;
      bus.dividend    = 16'd0;
      bus.divisor     = 16'd0;
      repeat (2) @(negedge clk);
      check("rst/ready",     16'(bus.ready),       16'd1);
      check("rst/busy",      16'(bus.busy),        16'd0);
      check("rst/done",      16'(bus.done),        16'd0);
      check("rst/quotient",  bus.quotient,         16'd0);
      check("rst/remainder", bus.remainder,        16'd0);
      check("rst/flags",     16'({bus.div_by_zero, bus.overflow}), 16'd0);
      reset = 1'b0;
      @(negedge clk);

      //      name        sm    dividend  divisor   quotient  remainder dbz   ovf
      run_op("u100_7",    1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0);
      run_op("sm100_7",   1'b1, 16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 1'b0);
      run_op("s100_m7",   1'b1, 16'd100,  16'hFFF9, 16'hFFF2, 16'd2,    1'b0, 1'b0);
      run_op("s_min_m1",  1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'd0,    1'b0, 1'b1);
      run_op("u_min_m1",  1'b0, 16'h8000, 16'hFFFF, 16'd0,    16'h8000, 1'b0, 1'b0);
      run_op("u1234_0",   1'b0, 16'd1234, 16'd0,    16'hFFFF, 16'd1234, 1'b1, 1'b0);
      run_op("s1234_0",   1'b1, 16'd1234, 16'd0,    16'hFFFF, 16'd1234, 1'b1, 1'b0);
      run_op("sm7_m2",    1'b1, 16'hFFF9, 16'hFFFE, 16'd3,    16'hFFFF, 1'b0, 1'b0);
      run_op("uffff_16",  1'b0, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 1'b0, 1'b0);
      run_op("u5_2",      1'b0, 16'd5,    16'd2,    16'd2,    16'd1,    1'b0, 1'b0);
      run_op("u0_9",      1'b0, 16'd0,    16'd9,    16'd0,    16'd0,    1'b0, 1'b0);

      // A start pulse mid-operation must be ignored.
      launch(1'b0, 16'hFFFF, 16'h0001, t0_main);
      push_exp("ign", 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'd0, 1'b0, 1'b0, t0_main);
      repeat (3) @(negedge clk);
      check("ign/busy",  16'(bus.busy),  16'd1);
      check("ign/ready", 16'(bus.ready), 16'd0);
      bus.start       = 1'b1;
      bus.signed_mode = 1'b1;
      bus.dividend    = 16'd9;
      bus.divisor     = 16'd3;
      @(negedge clk);
      bus.start = 1'b0;
      drain("ign");

      // Reset mid-operation aborts and clears everything.
      launch(1'b0, 16'hFFFF, 16'h0001, t0_main);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort/ready",     16'(bus.ready), 16'd1);
      check("abort/busy",      16'(bus.busy),  16'd0);
      check("abort/quotient",  bus.quotient,   16'd0);
      check("abort/remainder", bus.remainder,  16'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("post_abort/ready",    16'(bus.ready), 16'd1);
      check("post_abort/quotient", bus.quotient,   16'd0);
      check("post_abort/done",     16'(bus.done),  16'd0);

      run_op("u9_3", 1'b0, 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
